// File: rtl/rr_decoder_arbiter.sv
// Round-robin owner arbiter for a shared N-to-2**N decoder.
// Registered sel/en with one dead cycle between owners.
module rr_decoder_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  parameter int CW       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2**N-1:0] req,
  input  logic            done,
  output logic [N-1:0]    sel,
  output logic            en,
  output logic [2**N-1:0] gnt,
  output logic            busy,
  output logic            timeout
);

  localparam int M = 2**N;
  localparam logic [CW-1:0] LAST =
    CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t        state, state_d;
  logic [N-1:0]  ptr, ptr_d;
  logic [N-1:0]  sel_d;
  logic [N-1:0]  win, idx;
  logic [CW-1:0] cnt, cnt_d;
  logic          en_d, busy_d, to_d;
  logic          found;
  logic          rel_vol, rel_lim;

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = |req;
    for (int i = M - 1; i >= 0; i--) begin
      idx = ptr + i[N-1:0];
      if (req[idx]) win = idx;
    end
  end

  assign rel_vol = done | ~req[sel];
  assign rel_lim = (cnt == LAST);

  always_comb begin
    state_d = state;
    sel_d   = sel;
    en_d    = en;
    busy_d  = busy;
    to_d    = 1'b0;
    ptr_d   = ptr;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = win;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel_vol || rel_lim) begin
          state_d = GAP;
          en_d    = 1'b0;
          busy_d  = 1'b1;
          ptr_d   = sel + N'(1);
          to_d    = rel_lim & ~rel_vol;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      GAP: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = win;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_d;
      sel     <= sel_d;
      en      <= en_d;
      busy    <= busy_d;
      timeout <= to_d;
      ptr     <= ptr_d;
      cnt     <= cnt_d;
    end
  end

  assign gnt = en ? (M'(1) << sel) : '0;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter.
// Expected outputs are queued per step and popped after the edge.
module tb_rr_decoder_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic        en;
  logic [15:0] gnt;
  logic        busy;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  sel;
    logic        en;
    logic        busy;
    logic        to;
    logic [15:0] gnt;
  } exp_t;

  exp_t q[$];

  rr_decoder_arbiter #(
    .N(4),
    .HOLD_MAX(8),
    .CW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .done(done),
    .sel(sel),
    .en(en),
    .gnt(gnt),
    .busy(busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input int es, input logic ee,
    input logic eb, input logic et
  );
    exp_t e;
    logic [15:0] one;
    one   = 16'h0001;
    e.sel = es[3:0];
    e.en  = ee;
    e.busy = eb;
    e.to  = et;
    e.gnt = ee ? (one << es) : 16'h0000;
    return e;
  endfunction

  task automatic check(input string tag);
    exp_t e;
    checks++;
    assert (q.size() != 0) else begin
      failures++;
      $error("FAIL %s queue empty obs=0 exp=1", tag);
    end
    if (q.size() == 0) return;
    e = q.pop_front();
    checks++;
    assert (sel === e.sel) else begin
      failures++;
      $error("FAIL %s.sel obs=%0d exp=%0d",
             tag, sel, e.sel);
    end
    checks++;
    assert (en === e.en) else begin
      failures++;
      $error("FAIL %s.en obs=%b exp=%b",
             tag, en, e.en);
    end
    checks++;
    assert (busy === e.busy) else begin
      failures++;
      $error("FAIL %s.busy obs=%b exp=%b",
             tag, busy, e.busy);
    end
    checks++;
    assert (timeout === e.to) else begin
      failures++;
      $error("FAIL %s.timeout obs=%b exp=%b",
             tag, timeout, e.to);
    end
    checks++;
    assert (gnt === e.gnt) else begin
      failures++;
      $error("FAIL %s.gnt obs=%h exp=%h",
             tag, gnt, e.gnt);
    end
    checks++;
    assert ($onehot0(gnt)) else begin
      failures++;
      $error("FAIL %s.onehot obs=%h exp=onehot0",
             tag, gnt);
    end
  endtask

  task automatic step(
    input logic [15:0] r, input logic d,
    input int es, input logic ee,
    input logic eb, input logic et,
    input string tag
  );
    req  = r;
    done = d;
    q.push_back(mk(es, ee, eb, et));
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    req  = '0;
    done = 1'b0;
    rst  = 1'b1;
    q.push_back(mk(0, 0, 0, 0));
    #2;
    check("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      step(16'h0, 0, 0, 0, 0, 0, "idle");

    // single request, done in 3rd grant cycle
    step(16'h0020, 0, 5, 1, 1, 0, "s_g1");
    step(16'h0020, 0, 5, 1, 1, 0, "s_g2");
    step(16'h0020, 0, 5, 1, 1, 0, "s_g3");
    step(16'h0020, 1, 5, 0, 1, 0, "s_gap");
    step(16'h0000, 0, 5, 0, 0, 0, "s_idle");
    // ptr=6 must pick 6 over 0
    step(16'h0041, 0, 6, 1, 1, 0, "p6_g");
    step(16'h0001, 0, 6, 0, 1, 0, "drop_gap");
    step(16'h0001, 0, 0, 1, 1, 0, "gap_regnt");
    step(16'h0000, 0, 0, 0, 1, 0, "drop0_gap");
    step(16'h0000, 0, 0, 0, 0, 0, "drop0_idle");

    // fairness, ptr=1 so 15 goes first
    for (int k = 0; k < 4; k++) begin
      int o;
      o = (k % 2 == 0) ? 15 : 0;
      step(16'h8001, 0, o, 1, 1, 0, "rr_g1");
      step(16'h8001, 0, o, 1, 1, 0, "rr_g2");
      step(16'h8001, 1, o, 0, 1, 0, "rr_gap");
    end
    step(16'h0000, 0, 0, 0, 0, 0, "rr_idle");

    // wrap-around after serving 14
    step(16'h4000, 0, 14, 1, 1, 0, "w14_g");
    step(16'h4000, 1, 14, 0, 1, 0, "w14_gap");
    step(16'h0000, 0, 14, 0, 0, 0, "w14_idle");
    step(16'h4003, 0, 0, 1, 1, 0, "w_g0");
    step(16'h4003, 1, 0, 0, 1, 0, "w_gap0");
    step(16'h4003, 0, 1, 1, 1, 0, "w_g1");
    step(16'h4003, 1, 1, 0, 1, 0, "w_gap1");
    step(16'h4003, 0, 14, 1, 1, 0, "w_g14");
    step(16'h4003, 1, 14, 0, 1, 0, "w_gap14");
    step(16'h0000, 0, 14, 0, 0, 0, "w_idle");

    // hold limit: 8 grant cycles then forced release
    for (int i = 0; i < 8; i++)
      step(16'h0100, 0, 8, 1, 1, 0, "hold_g");
    step(16'h0100, 0, 8, 0, 1, 1, "hold_to");
    for (int i = 0; i < 8; i++)
      step(16'h0100, 0, 8, 1, 1, 0, "hold_rg");
    // done on the last allowed cycle
    step(16'h0100, 1, 8, 0, 1, 0, "hold_done");
    step(16'h0000, 0, 8, 0, 0, 0, "hold_idle");

    // async reset mid-grant, then restart at ptr=0
    step(16'h0004, 0, 2, 1, 1, 0, "ar_g");
    req = 16'h8004;
    rst = 1'b1;
    q.push_back(mk(0, 0, 0, 0));
    #1;
    check("ar_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(16'h8004, 0, 2, 1, 1, 0, "ar_ptr0");
    step(16'h0000, 0, 2, 0, 1, 0, "ar_gap");
    step(16'h0000, 0, 2, 0, 0, 0, "ar_idle");

    // single-bit sweep
    for (int i = 0; i < 16; i++) begin
      logic [15:0] b;
      b = 16'h0001 << i;
      step(b, 0, i, 1, 1, 0, "sw_g");
      step(16'h0, 0, i, 0, 1, 0, "sw_gap");
      step(16'h0, 0, i, 0, 0, 0, "sw_idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
